// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_queue.sv
// Synchronous FIFO of fetched {pc, inst} pairs; flush empties it and beats push/pop.
module if_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;

    // Storage needs no reset; only entries below count_q are ever observed.
    always_ff @(posedge clk) begin
        if (reset && !flush && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch PC owner: issues reads to a 1-cycle instruction memory, queues the
// returned words for decode, and redirects on execute-stage jumps.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_VECTOR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   jump_flag,
    input  logic [XLEN-1:0]        jump_target,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    output logic                   if_valid,
    output logic [XLEN-1:0]        if_inst,
    output logic [XLEN-1:0]        if_pc,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] if_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [XLEN-1:0] fetch_pc_q, req_pc_q;
    logic            pending_q, kill_q;
    logic            push, pop, q_empty;
    logic [CW:0]     inflight;
    fetch_entry_t    head, push_data;
    logic            unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_target[1:0];

    // Count in-flight responses so every issued request already owns a slot.
    assign inflight  = {1'b0, if_count} + {{CW{1'b0}}, pending_q};
    assign imem_req  = reset & ~jump_flag & (inflight < DEPTH_W);
    assign imem_addr = fetch_pc_q;

    assign push      = pending_q & ~kill_q;
    assign push_data = '{pc: req_pc_q, inst: imem_rdata};
    assign pop       = if_valid & id_ready;

    assign if_valid  = ~q_empty;
    assign if_inst   = q_empty ? INST_NOP : head.inst;
    assign if_pc     = q_empty ? '0 : head.pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            pending_q  <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pending_q <= imem_req;
            kill_q    <= jump_flag & pending_q;
            if (imem_req) req_pc_q <= fetch_pc_q;
            if (jump_flag) begin
                fetch_pc_q <= {jump_target[XLEN-1:2], 2'b00};
            end else if (imem_req) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    if_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (jump_flag),
        .head      (head),
        .empty     (q_empty),
        .count     (if_count)
    );

endmodule
